// File: rtl/reg_file_wb_pkg.sv
//==============================================================================
// Module      : reg_file_wb_pkg
// Description : Shared pipeline constants and dump-FSM state encoding for the
//               architectural register file.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package reg_file_wb_pkg;

    // Register index width (32 architectural registers)
    localparam int ADDR_W = 5;

    // Hard-wired zero register and stack pointer indices
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;

    // Dump streaming state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage : reg_file_wb_pkg

`default_nettype wire

// File: rtl/reg_file_wb_if.sv
//==============================================================================
// Module      : reg_file_wb_if
// Description : Bundle of writeback, read-port and dump-stream signals between
//               the pipeline (master) and the register file (slave).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface reg_file_wb_if #(
    parameter int DATA_W = 32
);
    import reg_file_wb_pkg::*;

    // Writeback port
    logic              FREEZE;
    logic              do_writeback;
    logic [ADDR_W-1:0] writeRegister;
    logic [DATA_W-1:0] writeData;

    // Decode read ports
    logic [ADDR_W-1:0] readRegA;
    logic [ADDR_W-1:0] readRegB;
    logic [DATA_W-1:0] readDataA;
    logic [DATA_W-1:0] readDataB;

    // Dump stream
    logic              dump_req;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_index;
    logic [DATA_W-1:0] dump_data;
    logic              dump_busy;
    logic              dump_done;

    // Pipeline / testbench side
    modport master (
        output FREEZE, do_writeback, writeRegister, writeData,
        output readRegA, readRegB,
        output dump_req, dump_ready,
        input  readDataA, readDataB,
        input  dump_valid, dump_index, dump_data, dump_busy, dump_done
    );

    // Register file side
    modport slave (
        input  FREEZE, do_writeback, writeRegister, writeData,
        input  readRegA, readRegB,
        input  dump_req, dump_ready,
        output readDataA, readDataB,
        output dump_valid, dump_index, dump_data, dump_busy, dump_done
    );

endinterface : reg_file_wb_if

`default_nettype wire

// File: rtl/reg_file_wb_dump_fsm.sv
//==============================================================================
// Module      : reg_file_dump_fsm
// Description : Streams every register out as valid/ready beats. The parent
//               supplies the value of the index named by cap_idx (including
//               same-edge writeback bypass); this block registers it.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module reg_file_dump_fsm
    import reg_file_wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  wire logic              CLK,
    input  wire logic              RESET,
    input  wire logic              dump_req,
    input  wire logic              dump_ready,
    input  wire logic [DATA_W-1:0] cap_data,
    output logic      [ADDR_W-1:0] cap_idx,
    output logic                   dump_valid,
    output logic      [ADDR_W-1:0] dump_index,
    output logic      [DATA_W-1:0] dump_data,
    output logic                   dump_busy,
    output logic                   dump_done
);

    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);

    dump_state_t r_state;
    logic        w_accept;

    assign w_accept = dump_valid && dump_ready;

    // Index whose value gets registered at the next edge: register 0 when a
    // dump starts, otherwise the one following the beat being presented.
    assign cap_idx = (r_state == SEND) ? (dump_index + 5'd1) : REG_ZERO;

    // Dump state machine with registered handshake outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= IDLE;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
            dump_index <= REG_ZERO;
            dump_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    dump_done <= 1'b0;
                    if (dump_req) begin
                        r_state    <= SEND;
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                        dump_index <= REG_ZERO;
                        dump_data  <= cap_data;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        if (dump_index == c_last_idx) begin
                            r_state    <= DONE;
                            dump_valid <= 1'b0;
                            dump_busy  <= 1'b0;
                            dump_done  <= 1'b1;
                        end else begin
                            dump_index <= dump_index + 5'd1;
                            dump_data  <= cap_data;
                        end
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    dump_done <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                    dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule : reg_file_dump_fsm

`default_nettype wire

// File: rtl/reg_file_wb.sv
//==============================================================================
// Module      : reg_file_wb
// Description : Architectural register file at the end of the writeback path.
//               One write per cycle, two combinational read ports with
//               write-through bypass, and a valid/ready dump stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module reg_file_wb
    import reg_file_wb_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 32,
    parameter logic [DATA_W-1:0]   SP_RESET = 32'h0000_0000
) (
    input  wire logic     CLK,
    input  wire logic     RESET,
    reg_file_wb_if.slave  bus
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_we;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [ADDR_W-1:0] w_cap_idx;
    logic [DATA_W-1:0] w_cap_data;

    // Architectural write: frozen pipeline holds the write, r0 is never written
    assign w_we = bus.do_writeback && !bus.FREEZE && (bus.writeRegister != REG_ZERO);

    // Register array with stack pointer reset value
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
            end
        end else if (w_we) begin
            r_regs[bus.writeRegister] <= bus.writeData;
        end
    end

    // Read port A: the bypass ignores FREEZE since a held WB value commits
    // on the first unfrozen edge anyway.
    always_comb begin
        w_rd_a = r_regs[bus.readRegA];
        if (bus.readRegA == REG_ZERO) begin
            w_rd_a = '0;
        end else if (bus.do_writeback && (bus.writeRegister == bus.readRegA)) begin
            w_rd_a = bus.writeData;
        end
    end

    // Read port B: same structure as port A
    always_comb begin
        w_rd_b = r_regs[bus.readRegB];
        if (bus.readRegB == REG_ZERO) begin
            w_rd_b = '0;
        end else if (bus.do_writeback && (bus.writeRegister == bus.readRegB)) begin
            w_rd_b = bus.writeData;
        end
    end

    // Dump capture mux: forwards only a write that actually commits at this
    // edge, so the dump reflects the architectural state after the edge.
    always_comb begin
        w_cap_data = r_regs[w_cap_idx];
        if (w_cap_idx == REG_ZERO) begin
            w_cap_data = '0;
        end else if (w_we && (bus.writeRegister == w_cap_idx)) begin
            w_cap_data = bus.writeData;
        end
    end

    assign bus.readDataA = w_rd_a;
    assign bus.readDataB = w_rd_b;

    reg_file_dump_fsm #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_dump_fsm (
        .CLK        (CLK),
        .RESET      (RESET),
        .dump_req   (bus.dump_req),
        .dump_ready (bus.dump_ready),
        .cap_data   (w_cap_data),
        .cap_idx    (w_cap_idx),
        .dump_valid (bus.dump_valid),
        .dump_index (bus.dump_index),
        .dump_data  (bus.dump_data),
        .dump_busy  (bus.dump_busy),
        .dump_done  (bus.dump_done)
    );

endmodule : reg_file_wb

`default_nettype wire

// File: tb/tb_reg_file_wb.sv
//==============================================================================
// Module      : tb_reg_file_wb
// Description : Scoreboard testbench for reg_file_wb. Stimulus queues expected
//               read results and dump beats; a monitor compares them on the
//               falling clock edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reg_file_wb;
    import reg_file_wb_pkg::*;

    localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    reg_file_wb_if #(.DATA_W(32)) bus ();

    reg_file_wb #(
        .DATA_W   (32),
        .NUM_REGS (32),
        .SP_RESET (SP_VAL)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
    } rd_exp_t;

    typedef struct {
        logic        is_done;
        logic [4:0]  idx;
        logic [31:0] data;
    } dump_exp_t;

    rd_exp_t   rd_q[$];
    dump_exp_t dump_q[$];
    logic      rd_strobe = 1'b0;
    logic      prev_beat31 = 1'b0;
    int        checks = 0;
    int        errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
        rd_strobe = 1'b0;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] r, input logic [31:0] d);
        bus.do_writeback  = en;
        bus.writeRegister = r;
        bus.writeData     = d;
    endtask

    task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
        bus.readRegA = a;
        bus.readRegB = b;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] a, input logic [31:0] b);
        rd_q.push_back('{name, a, b});
        rd_strobe = 1'b1;
    endtask

    task automatic push_beat(input logic [4:0] idx, input logic [31:0] data);
        dump_q.push_back('{1'b0, idx, data});
    endtask

    task automatic monitor();
        rd_exp_t   re;
        dump_exp_t de;
        logic      acc31;
        forever begin
            @(negedge CLK);
            if (rd_strobe) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got strobe expected queued read");
                end else begin
                    re = rd_q.pop_front();
                    check32({re.name, "_A"}, bus.readDataA, re.a);
                    check32({re.name, "_B"}, bus.readDataB, re.b);
                end
            end
            acc31 = bus.dump_valid && bus.dump_ready && (bus.dump_index == 5'd31);
            if (bus.dump_valid && bus.dump_ready) begin
                if (dump_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dump_unexpected: got beat %0d expected none", bus.dump_index);
                end else begin
                    de = dump_q.pop_front();
                    check32("beat_kind", 32'(de.is_done), 32'd0);
                    check32("beat_index", 32'(bus.dump_index), 32'(de.idx));
                    check32("beat_data", bus.dump_data, de.data);
                    check32("beat_busy", 32'(bus.dump_busy), 32'd1);
                end
            end
            if (bus.dump_done) begin
                if (dump_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got dump_done expected none");
                end else begin
                    de = dump_q.pop_front();
                    check32("done_kind", 32'(de.is_done), 32'd1);
                    check32("done_after_beat31", 32'(prev_beat31), 32'd1);
                    check32("done_busy", 32'(bus.dump_busy), 32'd0);
                end
            end
            prev_beat31 = acc31;
        end
    endtask

    initial begin
        int  cnt;
        logic found;

        bus.FREEZE = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        set_rd(5'd0, 5'd0);
        bus.dump_req   = 1'b0;
        bus.dump_ready = 1'b0;

        fork
            monitor();
            begin
                #500000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state of the dump outputs
        repeat (2) @(posedge CLK);
        #1;
        check32("rst_dump_valid", 32'(bus.dump_valid), 32'd0);
        check32("rst_dump_busy",  32'(bus.dump_busy),  32'd0);
        check32("rst_dump_done",  32'(bus.dump_done),  32'd0);
        check32("rst_dump_index", 32'(bus.dump_index), 32'd0);
        check32("rst_dump_data",  bus.dump_data,       32'd0);
        RESET = 1'b1;

        // 1: reset register contents
        for (int i = 0; i < 32; i++) begin
            cyc();
            set_rd(5'(i), 5'(31 - i));
            expect_rd("reset_rd", (i == 29) ? SP_VAL : 32'h0, ((31 - i) == 29) ? SP_VAL : 32'h0);
        end

        // 2: bypass then commit
        cyc(); set_wb(1'b1, 5'd5, 32'hDEAD_BEEF); set_rd(5'd5, 5'd29);
        expect_rd("wb_bypass", 32'hDEAD_BEEF, SP_VAL);
        cyc(); set_wb(1'b0, 5'd5, 32'hDEAD_BEEF);
        expect_rd("wb_commit", 32'hDEAD_BEEF, SP_VAL);

        // 3: r0 is hard-wired zero
        cyc(); set_wb(1'b1, 5'd0, 32'h1234); set_rd(5'd0, 5'd0);
        expect_rd("r0_same", 32'h0, 32'h0);
        cyc(); set_wb(1'b0, 5'd0, 32'h1234);
        expect_rd("r0_next", 32'h0, 32'h0);

        // 4: freeze blocks the write but not the bypass
        cyc(); bus.FREEZE = 1'b1; set_wb(1'b1, 5'd7, 32'h55); set_rd(5'd7, 5'd5);
        expect_rd("freeze_bypass", 32'h55, 32'hDEAD_BEEF);
        cyc(); set_wb(1'b0, 5'd7, 32'h55);
        expect_rd("freeze_hold", 32'h0, 32'hDEAD_BEEF);
        cyc(); bus.FREEZE = 1'b0; set_wb(1'b1, 5'd7, 32'h55);
        expect_rd("unfreeze_bypass", 32'h55, 32'hDEAD_BEEF);
        cyc(); set_wb(1'b0, 5'd7, 32'h55);
        expect_rd("unfreeze_commit", 32'h55, 32'hDEAD_BEEF);

        // 5: preload rK = K + 100, then full-speed dump
        for (int k = 1; k < 32; k++) begin
            cyc(); set_wb(1'b1, 5'(k), 32'(k + 100)); set_rd(5'(k), 5'd0);
            expect_rd("preload_bypass", 32'(k + 100), 32'h0);
        end
        cyc(); set_wb(1'b0, 5'd0, 32'h0);
        bus.dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) push_beat(5'(i), (i == 0) ? 32'h0 : 32'(i + 100));
        dump_q.push_back('{1'b1, 5'd0, 32'h0});
        bus.dump_req = 1'b1;
        cyc(); bus.dump_req = 1'b0;
        check32("first_beat_valid", 32'(bus.dump_valid), 32'd1);
        check32("first_beat_busy",  32'(bus.dump_busy),  32'd1);
        cnt = 1;
        while (!bus.dump_done && cnt < 100) begin
            cyc();
            cnt++;
        end
        check32("done_cycle", 32'(cnt), 32'd33);
        cyc();
        check32("post_done_pulse", 32'(bus.dump_done), 32'd0);
        check32("post_done_busy",  32'(bus.dump_busy),  32'd0);

        // 6: stalled beat, capture bypass, reset mid-stream
        for (int i = 0; i < 10; i++) begin
            case (i)
                0:       push_beat(5'd0, 32'h0);
                4:       push_beat(5'd4, 32'hBBBB);
                default: push_beat(5'(i), 32'(i + 100));
            endcase
        end
        bus.dump_ready = 1'b1;
        bus.dump_req = 1'b1;
        cyc(); bus.dump_req = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            if (bus.dump_valid && bus.dump_index == 5'd3) found = 1'b1;
            else cyc();
        end
        check32("wait_idx3", 32'(found), 32'd1);
        bus.dump_ready = 1'b0;
        set_wb(1'b1, 5'd3, 32'hAAAA); set_rd(5'd3, 5'd4);
        expect_rd("stall_bypass", 32'hAAAA, 32'd104);
        repeat (4) cyc();
        bus.dump_ready = 1'b1;
        set_wb(1'b1, 5'd4, 32'hBBBB);
        expect_rd("resume_rd", 32'hAAAA, 32'hBBBB);
        cyc(); set_wb(1'b0, 5'd0, 32'h0);
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            if (bus.dump_valid && bus.dump_index == 5'd10) found = 1'b1;
            else cyc();
        end
        check32("wait_idx10", 32'(found), 32'd1);
        bus.dump_ready = 1'b0;
        set_rd(5'd3, 5'd29);
        expect_rd("post_reset_rd", 32'h0, SP_VAL);
        #2;
        RESET = 1'b0;
        #1;
        check32("async_rst_valid", 32'(bus.dump_valid), 32'd0);
        check32("async_rst_busy",  32'(bus.dump_busy),  32'd0);
        cyc();
        RESET = 1'b1;
        bus.dump_ready = 1'b1;
        repeat (3) cyc();
        check32("idle_valid", 32'(bus.dump_valid), 32'd0);
        check32("idle_busy",  32'(bus.dump_busy),  32'd0);
        check32("idle_index", 32'(bus.dump_index), 32'd0);
        check32("rd_q_empty",   32'(rd_q.size()),   32'd0);
        check32("dump_q_empty", 32'(dump_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file_wb

`default_nettype wire
